// File: rtl/fifo_write_ctrl_if.sv
// Write-side bundle of the dual-clock FIFO: client request/flush inputs,
// the read-domain Gray pointer, and the RAM strobe and flag outputs.
interface fifo_write_ctrl_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  flush;
  logic                  wr_enable;
  logic                  clr_overflow;
  logic [ADDR_WIDTH:0]   rd_ptr_gray;
  logic                  fifo_wr_enable;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH:0]   wr_ptr_gray;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   wr_count;
  logic                  overflow;

  modport master (
    output flush, wr_enable, clr_overflow, rd_ptr_gray,
    input  fifo_wr_enable, wr_addr, wr_ptr_gray, full, almost_full, wr_count, overflow
  );

  modport slave (
    input  flush, wr_enable, clr_overflow, rd_ptr_gray,
    output fifo_wr_enable, wr_addr, wr_ptr_gray, full, almost_full, wr_count, overflow
  );
endinterface

// File: rtl/fifo_write_ctrl.sv
// Write-domain pointer/flag controller of the dual-clock FIFO: binary+Gray write
// pointer, read-pointer synchroniser, registered full/almost_full/count, overflow, flush.
module fifo_write_ctrl #(
  parameter int ADDR_WIDTH   = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 12
) (
  input  logic              w_clk,
  input  logic              wresetn,
  fifo_write_ctrl_if.slave  bus
);

  localparam int PW = ADDR_WIDTH + 1;
  // Gray of (ptr + DEPTH) is Gray of ptr with its two top bits inverted.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

  typedef enum logic { RUN, FLUSH } state_t;

  state_t        state;
  logic [PW-1:0] wr_bin;
  logic [PW-1:0] wr_gray;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] rq;
  logic [PW-1:0] rbin;
  logic [PW-1:0] wb_n;
  logic [PW-1:0] count_n;
  logic          full_n;
  logic          afull_n;
  logic          wr_go;
  logic          ovf_set;
  logic          full_q;
  logic          afull_q;
  logic [PW-1:0] count_q;
  logic          ovf_q;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  assign rq      = sync_q[SYNC_STAGES-1];
  assign rbin    = gray2bin(rq);
  assign wr_go   = bus.wr_enable & ~full_q & (state == RUN) & ~bus.flush;
  assign ovf_set = bus.wr_enable &  full_q & (state == RUN) & ~bus.flush;

  // NOTE: every always_comb output gets a value up front, so no path can infer a latch.
  always_comb begin
    wb_n    = wr_bin + PW'(wr_go);
    count_n = wb_n - rbin;
    full_n  = (bin2gray(wb_n) == (rq ^ FULL_MASK));
    afull_n = (count_n >= PW'(AFULL_THRESH));
  end

  // Read pointer crosses from r_clk; flush deliberately leaves these flops alone.
  // NOTE: the synchroniser is a small flop chain, not RAM, so it takes the async reset.
  always_ff @(posedge w_clk or negedge wresetn) begin
    if (!wresetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.rd_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge w_clk or negedge wresetn) begin
    if (!wresetn) begin
      state   <= RUN;
      wr_bin  <= '0;
      wr_gray <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (ovf_set)               ovf_q <= 1'b1;
      else if (bus.clr_overflow) ovf_q <= 1'b0;

      case (state)
        RUN: begin
          if (bus.flush) begin
            state   <= FLUSH;
            wr_bin  <= '0;
            wr_gray <= '0;
            count_q <= '0;
            afull_q <= 1'b0;
            full_q  <= 1'b1;
          end else begin
            wr_bin  <= wb_n;
            wr_gray <= bin2gray(wb_n);
            full_q  <= full_n;
            count_q <= count_n;
            afull_q <= afull_n;
          end
        end
        FLUSH: begin
          // Leave only once the read side shows an all-zero pointer.
          if (!bus.flush && rq == '0) begin
            state  <= RUN;
            full_q <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.fifo_wr_enable = wr_go;
  assign bus.wr_addr        = wr_bin[ADDR_WIDTH-1:0];
  assign bus.wr_ptr_gray    = wr_gray;
  assign bus.full           = full_q;
  assign bus.almost_full    = afull_q;
  assign bus.wr_count       = count_q;
  assign bus.overflow       = ovf_q;

endmodule
